bcd_scan_display: RTL



---
 rtl/bcd_disp_pkg.sv | 54 +++++
 rtl/seg7_decode.sv | 31 +++
 rtl/bcd_scan_display.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/bcd_disp_pkg.sv
// rtl/bcd_disp_pkg.sv - shared types, constants and digit map for the BCD scan display
package bcd_disp_pkg;

  typedef enum logic [1:0] {
    ST_RST  = 2'd0,
    ST_LOAD = 2'd1,
    ST_SCAN = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [7:0] AN_OFF    = 8'hFF;
  localparam logic [2:0] IDX_LAST  = 3'd7;

  // Which snapshot feeds a scan position, and which digit of it.
  typedef enum logic [1:0] {
    SRC_L    = 2'd0,
    SRC_T    = 2'd1,
    SRC_NONE = 2'd2
  } src_t;

  localparam logic [1:0] DIG_ONES = 2'd0;
  localparam logic [1:0] DIG_TENS = 2'd1;
  localparam logic [1:0] DIG_HUND = 2'd2;

  typedef struct packed {
    logic hund;
    logic tens;
  } lz_mask_t;

  function automatic src_t pos_src(input logic [2:0] idx);
    src_t s;
    case (idx)
      3'd0, 3'd1, 3'd2: s = SRC_L;
      3'd4, 3'd5, 3'd6: s = SRC_T;
      default:          s = SRC_NONE;
    endcase
    return s;
  endfunction

  function automatic logic [1:0] pos_digit(input logic [2:0] idx);
    return idx[1:0];
  endfunction

  // A non-decimal nibble is not zero, so it stops blanking to its right.
  function automatic lz_mask_t lz_mask(input logic [11:0] v, input logic en);
    lz_mask_t m;
    m.hund = en && (v[11:8] == 4'h0);
    m.tens = en && (v[11:4] == 8'h00);
    return m;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - BCD nibble to active-low 7-segment pattern {g,f,e,d,c,b,a}
module seg7_decode
  import bcd_disp_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    if (blank) begin
      seg = SEG_BLANK;
    end else begin
      case (nibble)
        4'd0:    seg = 7'h40;
        4'd1:    seg = 7'h79;
        4'd2:    seg = 7'h24;
        4'd3:    seg = 7'h30;
        4'd4:    seg = 7'h19;
        4'd5:    seg = 7'h12;
        4'd6:    seg = 7'h02;
        4'd7:    seg = 7'h78;
        4'd8:    seg = 7'h00;
        4'd9:    seg = 7'h10;
        default: seg = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/bcd_scan_display.sv
// rtl/bcd_scan_display.sv - frame-snapshotted 8-digit multiplexed display of two 3-digit BCD values
module bcd_scan_display
  import bcd_disp_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int GAP_CYC     = 64,
  parameter int CNT_W       = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] DT,
  input  logic [11:0] DL,
  input  logic        blank_en,
  output logic [6:0]  seg,
  output logic [7:0]  an,
  output logic        frame_tick
);

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYC - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [2:0]       r_idx;
  logic [2:0]       w_idx_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_load;
  logic             w_tick_nxt;

  logic [11:0]      r_snap_t;
  logic [11:0]      r_snap_l;
  lz_mask_t         r_mask_t;
  lz_mask_t         r_mask_l;

  src_t             w_src;
  logic [1:0]       w_dsel;
  logic [11:0]      w_val;
  lz_mask_t         w_mask;
  logic [3:0]       w_nibble;
  logic             w_blank;
  logic [6:0]       w_seg;
  logic [7:0]       w_an_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RST;
      r_idx   <= 3'd0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    w_tick_nxt  = 1'b0;
    case (r_state)
      ST_RST: begin
        w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        w_load      = 1'b1;
        w_idx_nxt   = 3'd0;
        w_cnt_nxt   = '0;
        w_state_nxt = ST_SCAN;
      end
      ST_SCAN: begin
        if (r_cnt == DWELL_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_GAP;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (r_cnt == GAP_LAST) begin
          w_cnt_nxt = '0;
          if (r_idx == IDX_LAST) begin
            w_tick_nxt  = 1'b1;
            w_state_nxt = ST_LOAD;
          end else begin
            w_idx_nxt   = r_idx + 3'd1;
            w_state_nxt = ST_SCAN;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_RST;
      end
    endcase
  end

  // Snapshot and blanking masks are frozen for the whole frame so a
  // half-updated upstream value never reaches the display.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_snap_t <= 12'h000;
      r_snap_l <= 12'h000;
      r_mask_t <= '0;
      r_mask_l <= '0;
    end else if (w_load) begin
      r_snap_t <= DT;
      r_snap_l <= DL;
      r_mask_t <= lz_mask(DT, blank_en);
      r_mask_l <= lz_mask(DL, blank_en);
    end
  end

  always_comb begin
    w_src    = pos_src(r_idx);
    w_dsel   = pos_digit(r_idx);
    w_val    = r_snap_l;
    w_mask   = r_mask_l;
    w_nibble = 4'h0;
    if (w_src == SRC_T) begin
      w_val  = r_snap_t;
      w_mask = r_mask_t;
    end
    case (w_dsel)
      DIG_ONES: w_nibble = w_val[3:0];
      DIG_TENS: w_nibble = w_val[7:4];
      default:  w_nibble = w_val[11:8];
    endcase
    w_blank = (r_state != ST_SCAN) ||
              (w_src == SRC_NONE) ||
              ((w_dsel == DIG_HUND) && w_mask.hund) ||
              ((w_dsel == DIG_TENS) && w_mask.tens);
    w_an_nxt = w_blank ? AN_OFF : ~(8'h01 << r_idx);
  end

  seg7_decode u_decode (
    .nibble (w_nibble),
    .blank  (w_blank),
    .seg    (w_seg)
  );

  // Registered outputs keep the anode/segment pins glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an         <= AN_OFF;
      seg        <= SEG_BLANK;
      frame_tick <= 1'b0;
    end else begin
      an         <= w_an_nxt;
      seg        <= w_seg;
      frame_tick <= w_tick_nxt;
    end
  end

endmodule
